// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encoding and a
// width helper reused by the sweeper and its hold timer.
package truth_table_sweeper_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int clog2_min1(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) width++;
        return width;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_hold_timer.sv
// Per-pattern hold timer: reloadable down-counter whose terminal-count pulse
// marks the last cycle of each input combination's hold.
module truth_table_sweeper_hold_timer
    import truth_table_sweeper_pkg::*;
#(
    parameter int HOLD_CYCLES = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = clog2_min1(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (en) begin
            count <= (count == '0) ? RELOAD : count - CNT_W'(1);
        end
    end

    assign tc = en && (count == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus-and-capture stage: walks abc through every combination,
// samples y_in at the end of each hold and publishes the captured truth table.
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter  int N_IN        = 3,
    parameter  int HOLD_CYCLES = 10,
    localparam int N_PAT       = 1 << N_IN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             y_in,
    output logic [N_IN-1:0]  abc,
    output logic             busy,
    output logic             done,
    output logic [N_PAT-1:0] table_out,
    output logic             table_valid
);

    localparam logic [N_IN-1:0] LAST_PAT = N_IN'(N_PAT - 1);

    state_t           state;
    logic [N_PAT-1:0] work_table;
    logic [N_PAT-1:0] merged_table;
    logic             accept;
    logic             sample;

    assign accept = (state == IDLE) && start;

    truth_table_sweeper_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (accept),
        .en   (state == DRIVE),
        .tc   (sample)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        merged_table      = work_table;
        merged_table[abc] = y_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            abc         <= '0;
            work_table  <= '0;
            table_out   <= '0;
            table_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state       <= DRIVE;
                        abc         <= '0;
                        work_table  <= '0;
                        busy        <= 1'b1;
                        table_valid <= 1'b0;
                        table_out   <= '0;
                    end
                end
                DRIVE: begin
                    if (sample) begin
                        work_table <= merged_table;
                        if (abc == LAST_PAT) begin
                            // Final sample publishes the table on the same edge.
                            state       <= DONE;
                            table_out   <= merged_table;
                            table_valid <= 1'b1;
                            done        <= 1'b1;
                            abc         <= '0;
                        end else begin
                            abc <= abc + N_IN'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: three parameterisations driven
// by table vectors, randomized truth tables and hand-written corner sequences.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] start_v;
    logic [2:0] busy_v, done_v, valid_v;
    logic       y0, y1, y2;
    logic [2:0] abc0, abc1;
    logic [1:0] abc2;
    logic [7:0] tbl0, tbl1;
    logic [3:0] tbl2;

    int         sel [3];
    logic [7:0] rand_tt [3];
    int         hold_of [3] = '{10, 1, 3};
    int         npat_of [3] = '{8, 8, 4};

    int n_checks = 0;
    int n_fail   = 0;

    // Function blocks under test; a=abc[2], b=abc[1], c=abc[0].
    function automatic logic fn(input int s, input int v, input logic [7:0] tt);
        logic a, b, c;
        a = 1'((v >> 2) & 1);
        b = 1'((v >> 1) & 1);
        c = 1'(v & 1);
        case (s)
            0:       return (a & b) | c;
            1:       return a ^ b ^ c;
            2:       return ~a;
            3:       return 1'b1;
            4:       return 1'((tt >> v) & 8'd1);
            5:       return b & c;          // two-input a&b on abc[1:0]
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] model_table(input int s, input int n, input logic [7:0] tt);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i] = fn(s, i, tt);
        return r;
    endfunction

    always_comb begin
        y0 = fn(sel[0], int'(abc0), rand_tt[0]);
        y1 = fn(sel[1], int'(abc1), rand_tt[1]);
        y2 = fn(sel[2], int'({1'b0, abc2}), rand_tt[2]);
    end

    truth_table_sweeper #(.N_IN(3), .HOLD_CYCLES(10)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .y_in(y0), .abc(abc0),
        .busy(busy_v[0]), .done(done_v[0]), .table_out(tbl0), .table_valid(valid_v[0]));
    truth_table_sweeper #(.N_IN(3), .HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .y_in(y1), .abc(abc1),
        .busy(busy_v[1]), .done(done_v[1]), .table_out(tbl1), .table_valid(valid_v[1]));
    truth_table_sweeper #(.N_IN(2), .HOLD_CYCLES(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .y_in(y2), .abc(abc2),
        .busy(busy_v[2]), .done(done_v[2]), .table_out(tbl2), .table_valid(valid_v[2]));

    // Uniform view of whichever instance is under test.
    int         cur;
    int         cur_abc;
    logic [7:0] cur_tbl;
    logic       cur_busy, cur_done, cur_valid;
    always_comb begin
        cur_abc   = 0;
        cur_tbl   = '0;
        case (cur)
            0: begin cur_abc = int'(abc0); cur_tbl = tbl0; end
            1: begin cur_abc = int'(abc1); cur_tbl = tbl1; end
            default: begin cur_abc = int'({1'b0, abc2}); cur_tbl = {4'h0, tbl2}; end
        endcase
        cur_busy  = busy_v[cur];
        cur_done  = done_v[cur];
        cur_valid = valid_v[cur];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One sweep with the start pulse at edge k; optional extra start pulse at j=poke_j.
    task automatic run_sweep(input int d, input int s, input logic [7:0] exp,
                             input int poke_j, input string name);
        int h, n, done_j, seq_err;
        h = hold_of[d];
        n = npat_of[d];
        done_j  = -1;
        seq_err = 0;
        cur     = d;
        sel[d]  = s;
        @(negedge clk);
        start_v[d] = 1'b1;
        @(negedge clk);
        start_v[d] = 1'b0;
        check({name, " accept valid"}, 32'(cur_valid), 32'd0);
        check({name, " accept table"}, 32'(cur_tbl), 32'd0);
        for (int j = 0; j <= n * h + 5; j++) begin
            start_v[d] = (j == poke_j);
            if (cur_done) begin
                done_j = j;
                break;
            end
            if (cur_abc != j / h || !cur_busy || cur_valid) seq_err++;
            @(negedge clk);
        end
        start_v[d] = 1'b0;
        check({name, " abc/busy sequence errors"}, 32'(seq_err), 32'd0);
        check({name, " done edge offset"}, 32'(done_j), 32'(n * h));
        check({name, " table_out"}, 32'(cur_tbl), 32'(exp));
        check({name, " table_valid"}, 32'(cur_valid), 32'd1);
        check({name, " busy in DONE"}, 32'(cur_busy), 32'd1);
        check({name, " abc back to 0"}, 32'(cur_abc), 32'd0);
        @(negedge clk);
        check({name, " done width"}, 32'(cur_done), 32'd0);
        check({name, " busy after DONE"}, 32'(cur_busy), 32'd0);
    endtask

    typedef struct {
        int         dut;
        int         s;
        logic [7:0] exp;
        int         poke_j;
        string      name;
    } vec_t;
    vec_t vecs [5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int errs, dones, d, done1, done2, idle_busy;
        logic [7:0] exp;

        vecs[0] = '{0, 0, 8'hEA, -1, "ab_or_c"};
        vecs[1] = '{1, 1, 8'h96, -1, "xor3_h1"};
        vecs[2] = '{0, 2, 8'h0F, 53, "not_a_restart_ignored"};
        vecs[3] = '{2, 5, 8'h08, -1, "and2_n2"};
        vecs[4] = '{0, 3, 8'hFF, -1, "const1"};

        rst_n   = 1'b0;
        start_v = '0;
        cur     = 0;
        for (int i = 0; i < 3; i++) begin sel[i] = 0; rand_tt[i] = '0; end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset table_out", {8'(tbl0), 8'(tbl1), 4'(tbl2)}, 32'd0);
        check("reset flags", {busy_v, done_v, valid_v}, 32'd0);
        check("reset abc", {abc0, abc1, abc2}, 32'd0);

        for (int i = 0; i < 5; i++)
            run_sweep(vecs[i].dut, vecs[i].s, vecs[i].exp, vecs[i].poke_j, vecs[i].name);

        // Result persists through idle cycles.
        errs = 0;
        cur = 0;
        repeat (50) begin
            @(negedge clk);
            if (cur_tbl !== 8'hFF || cur_valid !== 1'b1 || cur_busy !== 1'b0) errs++;
        end
        check("persistence errors", 32'(errs), 32'd0);

        // Randomized truth tables against the reference model.
        for (int r = 0; r < 8; r++) begin
            d = (r == 0) ? 0 : int'($urandom_range(0, 2));
            rand_tt[d] = 8'($urandom);
            exp = model_table(4, npat_of[d], rand_tt[d]);
            run_sweep(d, 4, exp, (r % 2 == 1) ? int'($urandom_range(1, 6)) : -1,
                      $sformatf("random%0d_dut%0d", r, d));
        end

        // start held high: back-to-back sweeps with one IDLE cycle between.
        cur = 1;
        sel[1] = 1;
        done1 = -1;
        done2 = -1;
        idle_busy = 1;
        errs = 0;
        @(negedge clk);
        start_v[1] = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 20; j++) begin
            if (j == 19) start_v[1] = 1'b0;
            if (cur_done) begin
                if (done1 < 0) done1 = j; else done2 = j;
                if (cur_tbl !== 8'h96) errs++;
            end
            if (j == 9) idle_busy = int'(cur_busy);
            @(negedge clk);
        end
        check("held start first done", 32'(done1), 32'd8);
        check("held start second done", 32'(done2), 32'd18);
        check("held start idle gap busy", 32'(idle_busy), 32'd0);
        check("held start table errors", 32'(errs), 32'd0);
        @(negedge clk);
        check("held start no third sweep", 32'(cur_busy), 32'd0);

        // Mid-sweep reset at abc==3.
        cur = 0;
        sel[0] = 0;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        errs = 1;
        for (int j = 0; j < 100; j++) begin
            if (cur_abc == 3) begin errs = 0; break; end
            @(negedge clk);
        end
        check("reach abc==3", 32'(errs), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid reset abc", 32'(cur_abc), 32'd0);
        check("mid reset table_out", 32'(cur_tbl), 32'd0);
        check("mid reset valid/busy/done", {cur_valid, cur_busy, cur_done}, 32'd0);
        dones = 0;
        repeat (100) begin
            @(negedge clk);
            if (cur_done || cur_busy) dones++;
        end
        check("no activity after mid reset", 32'(dones), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
